// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and widths for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int LOSS_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// pll_sup_sync: multi-flop synchronizer for one asynchronous PLL status bit
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic USR_RSTN,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] ff;

    // shift the async bit through STAGES flops, cleared by user reset
    always_ff @(posedge CLK) begin
        if (!USR_RSTN) ff <= '0;
        else ff <= {ff[STAGES-2:0], D};
    end

    assign Q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences PLL steady-lock reset, lock wait, settle and run
// Optional loss-event counter enabled by defining PLL_SUP_LOSS_COUNTER_EN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int STDY_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT    = 100,
    parameter int SETTLE_CYCLES   = 16,
    parameter int MAX_RETRIES     = 3
) (
    input  logic              CLK,
    input  logic              USR_RSTN,
    input  logic              PLL_LOCKED,
    input  logic              PLL_LOCKED_STDY,
    input  logic              RETRY,
    output logic              LOCKED_STDY_RST,
    output logic              SYS_RSTN,
    output logic              FAULT,
    output logic [2:0]        STATE,
    output logic [LOSS_W-1:0] LOSS_CNT
);

    localparam int CW = $clog2(max3(STDY_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          locked_s;
    logic          stdy_s;
    logic          good;
    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [RW-1:0] rty;
    logic [RW-1:0] rty_nx;
    logic          stdy_rst;
    logic          sys_rstn;
    logic          fault;

    pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .CLK      (CLK),
        .USR_RSTN (USR_RSTN),
        .D        (PLL_LOCKED),
        .Q        (locked_s)
    );

    pll_sup_sync #(.STAGES(SYNC_STAGES)) u_sync_stdy (
        .CLK      (CLK),
        .USR_RSTN (USR_RSTN),
        .D        (PLL_LOCKED_STDY),
        .Q        (stdy_s)
    );

    assign good = locked_s & stdy_s;

    // next state, cycle counter and retry count; counter only advances below its limit
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rty_nx   = rty;
        case (state)
            ST_RESET_PLL: begin
                if (cnt == CW'(STDY_RST_CYCLES - 1)) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + CW'(1);
            end
            ST_WAIT_LOCK: begin
                if (good) begin
                    state_nx = ST_SETTLE;
                    cnt_nx   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    rty_nx   = rty + RW'(1);
                    state_nx = (rty_nx == RW'(MAX_RETRIES)) ? ST_FAULT : ST_RESET_PLL;
                    cnt_nx   = '0;
                end else cnt_nx = cnt + CW'(1);
            end
            ST_SETTLE: begin
                if (!good) begin
                    state_nx = ST_WAIT_LOCK;
                    cnt_nx   = '0;
                end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_nx = ST_RUN;
                    cnt_nx   = '0;
                    rty_nx   = '0;
                end else cnt_nx = cnt + CW'(1);
            end
            ST_RUN: begin
                if (!good) begin
                    state_nx = ST_RESET_PLL;
                    cnt_nx   = '0;
                end
            end
            ST_FAULT: begin
                if (RETRY) begin
                    state_nx = ST_RESET_PLL;
                    cnt_nx   = '0;
                    rty_nx   = '0;
                end
            end
            default: begin
                state_nx = ST_RESET_PLL;
                cnt_nx   = '0;
            end
        endcase
    end

    // state register; outputs decoded from next state so they track the state register exactly
    always_ff @(posedge CLK) begin
        if (!USR_RSTN) begin
            state    <= ST_RESET_PLL;
            cnt      <= '0;
            rty      <= '0;
            stdy_rst <= 1'b1;
            sys_rstn <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rty      <= rty_nx;
            stdy_rst <= (state_nx == ST_RESET_PLL);
            sys_rstn <= (state_nx == ST_RUN);
            fault    <= (state_nx == ST_FAULT);
        end
    end

    assign LOCKED_STDY_RST = stdy_rst;
    assign SYS_RSTN        = sys_rstn;
    assign FAULT           = fault;
    assign STATE           = state;

`ifdef PLL_SUP_LOSS_COUNTER_EN
    logic [LOSS_W-1:0] loss_cnt;

    // count each RUN-to-reset lock loss, saturating at all ones
    always_ff @(posedge CLK) begin
        if (!USR_RSTN) loss_cnt <= '0;
        else if (state == ST_RUN && !good && loss_cnt != '1) loss_cnt <= loss_cnt + LOSS_W'(1);
    end

    assign LOSS_CNT = loss_cnt;
`else
    assign LOSS_CNT = '0;
`endif

endmodule
